run_controller: RTL
===================

Name: run_controller

Overview:
- Synthesizable run-control and performance-count unit between the testbench/host and the processor core.
- Replaces ad-hoc start/start_addr driving and testbench-side instruction counting.
- Launches a program at a given address, optionally repeats it N times, and counts retired instructions and cycles.
- Enforces a cycle watchdog and presents done/timeout status to the outside.

Parameters:
- PC_W, 8, width of program start address / PC load value.
- CNT_W, 32, width of instruction and cycle counters.
- REP_W, 4, width of repeat-count input.
- TIMEOUT_CYC, 20000, max cycles per run before watchdog abort; must be >= 2.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- start  in  1  single-cycle launch pulse.
- start_addr  in  PC_W  program start address; sampled with start.
- repeat_n  in  REP_W  number of back-to-back runs; sampled with start; 0 is treated as 1.
- abort  in  1  synchronous abort, any state.
- instr_retire  in  1  core retired one instruction this cycle.
- core_halt  in  1  core reached halt this cycle.
- core_rst  out  1  hold core in reset.
- pc_load  out  1  load core PC with pc_load_val.
- pc_load_val  out  PC_W  latched start address.
- busy  out  1  job in progress (LOAD or RUN).
- done  out  1  job finished; level signal.
- timeout  out  1  job ended by watchdog.
- instr_count  out  CNT_W  retired instructions, whole job.
- cycle_count  out  CNT_W  RUN cycles, whole job.
- last_run_instr  out  CNT_W  retired instructions of the most recently completed run.
- runs_left  out  REP_W  remaining runs including the current one.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - State is IDLE.
  - core_rst=1.
  - All other outputs are 0, including all counters and pc_load_val.
- States: IDLE, LOAD, RUN, DONE. Registered outputs change on the CLK edge after the cause.
- IDLE:
  - core_rst=1.
  - On start=1: latch start_addr into pc_load_val and max(repeat_n,1) into runs_left; clear instr_count, cycle_count, last_run_instr, timeout, done; go to LOAD.
- LOAD (exactly 1 cycle):
  - core_rst=1, pc_load=1, busy=1.
  - Clear the per-run instruction counter and per-run cycle counter; go to RUN.
- RUN:
  - core_rst=0, pc_load=0, busy=1.
  - Every cycle: cycle_count+1 and per-run cycle counter+1.
  - instr_retire=1: instr_count+1 and per-run counter+1.
  - Counters saturate at all-ones and never wrap.
- core_halt=1 in RUN:
  - last_run_instr <= per-run count, including any retire in the same cycle.
  - If runs_left>1: decrement runs_left and go to LOAD at the same pc_load_val.
  - Otherwise: set runs_left=0 and go to DONE.
- Watchdog: when the per-run cycle counter reaches TIMEOUT_CYC-1 and core_halt=0 in that cycle, set timeout=1, latch last_run_instr, and go to DONE regardless of runs_left. If halt and watchdog occur in the same cycle, halt wins and timeout stays 0.
- DONE:
  - done=1, busy=0, core_rst=1.
  - Counters and status are held.
  - start=1 launches a new job exactly as from IDLE.
- start in LOAD or RUN is ignored; no re-latch.
- abort=1 in any state: next state is IDLE and done=0. Counters and timeout are held for post-mortem. abort has priority over start, halt and watchdog.
- instr_retire and core_halt are ignored outside RUN.
- Asynchronous reset mid-RUN clears everything immediately; core_rst is asserted asynchronously.

Test Plan:
- Single run: start, start_addr=8'd75, repeat_n=0, 12 retire pulses, halt at RUN cycle 20 (retire also high that cycle).
  → pc_load_val=75 and pc_load high for 1 cycle.
  → instr_count=13, last_run_instr=13, cycle_count=20, done=1, timeout=0.
- Repeat: repeat_n=3, each run retires 5 instructions then halts.
  → exactly 3 LOAD pulses.
  → instr_count=15, last_run_instr=5, runs_left=0, done=1.
- Watchdog: TIMEOUT_CYC=50, core never halts, repeat_n=2.
  → timeout=1 and done=1 after 50 RUN cycles, cycle_count=50, only 1 LOAD pulse.
  → Repeat with halt on cycle 50: timeout=0.
- Saturation: CNT_W=4, retire every cycle for 20 cycles, then halt.
  → instr_count=15, cycle_count=15, no wrap.
- Abort/start collisions:
  - start during RUN → no change in pc_load_val.
  - abort together with halt → IDLE, done=0, counters held.
  - start in DONE → counters cleared, new LOAD.
- Reset mid-RUN: drop RESET_N asynchronously between clock edges.
  → core_rst=1 and all counters 0 before the next edge; state IDLE after release.

Source files
------------

// File: rtl/run_controller.sv
// Run-control and performance-count unit sitting between host and core.
// Launches a program at a latched address, optionally repeats it, counts
// retired instructions and RUN cycles, and aborts a run on watchdog expiry.
module run_controller #(
  parameter int PC_W        = 8,
  parameter int CNT_W       = 32,
  parameter int REP_W       = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic [REP_W-1:0] repeat_n,
  input  logic             abort,
  input  logic             instr_retire,
  input  logic             core_halt,
  output logic             core_rst,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_val,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] last_run_instr,
  output logic [REP_W-1:0] runs_left
);

  // Per-run cycle counter never exceeds TIMEOUT_CYC-1: the watchdog fires there.
  localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [REP_W-1:0]  runs_q, runs_d;
  logic [CNT_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  rinstr_q, rinstr_d;
  logic [WD_W-1:0]   rcyc_q, rcyc_d;
  logic              tout_q, tout_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
  endfunction

  // Next-state and counter update; abort overrides every other event.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    runs_d   = runs_q;
    instr_d  = instr_q;
    cyc_d    = cyc_q;
    last_d   = last_q;
    rinstr_d = rinstr_q;
    rcyc_d   = rcyc_q;
    tout_d   = tout_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            pc_d    = start_addr;
            runs_d  = (repeat_n == '0) ? REP_W'(1) : repeat_n;
            instr_d = '0;
            cyc_d   = '0;
            last_d  = '0;
            tout_d  = 1'b0;
            state_d = LOAD;
          end
        end
        LOAD: begin
          rinstr_d = '0;
          rcyc_d   = '0;
          state_d  = RUN;
        end
        RUN: begin
          cyc_d  = sat_inc(cyc_q);
          rcyc_d = rcyc_q + WD_W'(1);
          if (instr_retire) begin
            instr_d  = sat_inc(instr_q);
            rinstr_d = sat_inc(rinstr_q);
          end
          // Halt wins over a coincident watchdog expiry.
          if (core_halt) begin
            last_d = rinstr_d;
            if (runs_q > REP_W'(1)) begin
              runs_d  = runs_q - REP_W'(1);
              state_d = LOAD;
            end else begin
              runs_d  = '0;
              state_d = DONE;
            end
          end else if (rcyc_q == WD_LAST) begin
            tout_d  = 1'b1;
            last_d  = rinstr_d;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and counter registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      runs_q   <= '0;
      instr_q  <= '0;
      cyc_q    <= '0;
      last_q   <= '0;
      rinstr_q <= '0;
      rcyc_q   <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      runs_q   <= runs_d;
      instr_q  <= instr_d;
      cyc_q    <= cyc_d;
      last_q   <= last_d;
      rinstr_q <= rinstr_d;
      rcyc_q   <= rcyc_d;
      tout_q   <= tout_d;
    end
  end

  // Control outputs decode straight from the state register, so reset
  // asserts core_rst without waiting for a clock.
  assign core_rst       = (state_q != RUN);
  assign pc_load        = (state_q == LOAD);
  assign busy           = (state_q == LOAD) || (state_q == RUN);
  assign done           = (state_q == DONE);
  assign timeout        = tout_q;
  assign pc_load_val    = pc_q;
  assign runs_left      = runs_q;
  assign instr_count    = instr_q;
  assign cycle_count    = cyc_q;
  assign last_run_instr = last_q;

endmodule
